// File: rtl/split_sched_pkg.sv
// Shared types and constants for the split scheduler: destination decode,
// credit counter type and the output-stage state encoding.
package split_sched_pkg;

  localparam int PKT_W           = 11;
  localparam int DEST_W          = 2;
  localparam int NUM_PORTS       = 4;
  localparam int CRED_W_DEF      = 3;
  localparam int CREDIT_INIT_DEF = 4;

  typedef logic [DEST_W-1:0]     dest_t;
  typedef logic [CRED_W_DEF-1:0] credit_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Destination port lives in the two most significant packet bits.
  function automatic dest_t get_dest(input logic [PKT_W-1:0] pkt);
    return pkt[PKT_W-1 -: DEST_W];
  endfunction

endpackage

// File: rtl/split_sched_if.sv
// Requester, split and credit-return signals of the scheduler bundled together.
// master = scheduler side, slave = requesters / split / downstream buffers.
interface split_sched_if
  import split_sched_pkg::*;
#(
  parameter int DATA_W  = PKT_W,
  parameter int NUM_REQ = NUM_PORTS
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      sp_valid;
  logic                      sp_ready;
  logic [DEST_W-1:0]         sp_ctrl;
  logic [DATA_W-1:0]         sp_data;
  logic [NUM_PORTS-1:0]      credit_return;
  logic [1:0]                grant_id;
  logic                      credit_ovf;

  modport master (
    input  req_valid, req_data, sp_ready, credit_return,
    output req_ready, sp_valid, sp_ctrl, sp_data, grant_id, credit_ovf
  );

  modport slave (
    output req_valid, req_data, sp_ready, credit_return,
    input  req_ready, sp_valid, sp_ctrl, sp_data, grant_id, credit_ovf
  );

endinterface

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin select: first eligible requester at or
// after ptr, wrapping 3 -> 0.
module rr_arb4 (
  input  logic [3:0] elig,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] idx
);

  logic       found;
  logic [1:0] cand;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (!found && elig[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/split_sched.sv
// Router input-stage scheduler: round-robin grant of four requesters onto one
// 4-way split, with per-output-port credit tracking and a one-entry output stage.
module split_sched
  import split_sched_pkg::*;
#(
  parameter int DATA_W      = PKT_W,
  parameter int NUM_REQ     = NUM_PORTS,
  parameter int CREDIT_INIT = CREDIT_INIT_DEF,
  parameter int CRED_W      = CRED_W_DEF
) (
  input logic          clk,
  input logic          reset,
  split_sched_if.master bus
);

  if (CREDIT_INIT >= 2**CRED_W) begin : g_bad_credit_w
    $error("CREDIT_INIT must fit in CRED_W bits");
  end
  if (DATA_W != PKT_W || NUM_REQ != NUM_PORTS) begin : g_bad_shape
    $error("split_sched supports only the package packet width and 4 requesters");
  end

  localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(CREDIT_INIT);

  out_state_e         state_q, state_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  dest_t              sp_ctrl_q, sp_ctrl_d;
  logic [DATA_W-1:0]  sp_data_q, sp_data_d;
  logic [1:0]         grant_id_q, grant_id_d;
  logic               ovf_q, ovf_d;
  logic [CRED_W-1:0]  credit_q [NUM_PORTS];
  logic [CRED_W-1:0]  credit_d [NUM_PORTS];

  logic               can_load;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] gnt;
  logic [1:0]         win_idx;
  logic               any_grant;
  dest_t              win_dest;
  dest_t              req_dest [NUM_REQ];
  logic [DATA_W-1:0]  req_pkt  [NUM_REQ];
  logic [NUM_PORTS-1:0] cred_dec;

  // In FULL sp_valid is high, so a ready split frees the stage this cycle.
  assign can_load = (state_q == ST_EMPTY) || bus.sp_ready;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      req_pkt[k]  = bus.req_data[k*DATA_W +: DATA_W];
      req_dest[k] = get_dest(req_pkt[k]);
      elig[k]     = bus.req_valid[k] && can_load && (credit_q[req_dest[k]] != '0);
    end
  end

  rr_arb4 u_arb (
    .elig (elig),
    .ptr  (rr_ptr_q),
    .gnt  (gnt),
    .idx  (win_idx)
  );

  assign any_grant = |gnt;
  assign win_dest  = req_dest[win_idx];

  // Grant is combinational, so it must be gated while reset is held.
  assign bus.req_ready  = reset ? '0 : gnt;
  assign bus.sp_valid   = (state_q == ST_FULL);
  assign bus.sp_ctrl    = sp_ctrl_q;
  assign bus.sp_data    = sp_data_q;
  assign bus.grant_id   = grant_id_q;
  assign bus.credit_ovf = ovf_q;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    sp_ctrl_d  = sp_ctrl_q;
    sp_data_d  = sp_data_q;
    grant_id_d = grant_id_q;
    if (any_grant) begin
      state_d    = ST_FULL;
      rr_ptr_d   = win_idx + 2'd1;
      sp_ctrl_d  = win_dest;
      sp_data_d  = req_pkt[win_idx];
      grant_id_d = win_idx;
    end else if (state_q == ST_FULL && bus.sp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // A return coinciding with a decrement on the same port cancels out; a lone
  // return to a full counter is dropped and flagged.
  always_comb begin
    ovf_d = ovf_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      cred_dec[p] = any_grant && (win_dest == dest_t'(p));
      credit_d[p] = credit_q[p];
      if (cred_dec[p] && !bus.credit_return[p]) begin
        credit_d[p] = credit_q[p] - 1'b1;
      end else if (bus.credit_return[p] && !cred_dec[p]) begin
        if (credit_q[p] == CRED_FULL) ovf_d = 1'b1;
        else                          credit_d[p] = credit_q[p] + 1'b1;
      end
    end
  end

  // NOTE: the credit array is architectural state, not a data buffer, so it is
  // reset with everything else; all flops update with non-blocking '<='.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      rr_ptr_q   <= '0;
      sp_ctrl_q  <= '0;
      sp_data_q  <= '0;
      grant_id_q <= '0;
      ovf_q      <= 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) credit_q[p] <= CRED_FULL;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      sp_ctrl_q  <= sp_ctrl_d;
      sp_data_q  <= sp_data_d;
      grant_id_q <= grant_id_d;
      ovf_q      <= ovf_d;
      for (int p = 0; p < NUM_PORTS; p++) credit_q[p] <= credit_d[p];
    end
  end

endmodule
